// File: rtl/tpu_pkg.sv
// Shared types and width helpers for the TPU tile controller and its input FIFO.
package tpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FEED    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_ERROR   = 2'd3
    } tile_state_e;

    // One input beat carries an A vector and a B vector of the tile.
    function automatic int beat_width(input int dim, input int dw);
        return 2 * dim * dw;
    endfunction

    function automatic int row_width(input int dim, input int dw);
        return dim * dw;
    endfunction

endpackage

// File: rtl/tpu_beat_fifo.sv
// Power-of-two circular FIFO holding k-slice beats ahead of the systolic array.
module tpu_beat_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [DATA_WIDTH-1:0]   din_i,
    output logic [DATA_WIDTH-1:0]   dout_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW:0]           count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are exactly PW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/tpu_tile_ctrl.sv
// Tiles an m x n x k job over an ARRAY_DIM systolic array: feeds k beats per tile,
// collects ARRAY_DIM result rows and serializes the unmasked elements.
module tpu_tile_ctrl
    import tpu_pkg::*;
#(
    parameter int ARRAY_DIM  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    input  logic                                         abort,
    input  logic                                         accumulate_mode,
    input  logic [3*DIM_WIDTH-1:0]                       cfg_dims,
    input  logic                                         in_valid,
    input  logic [beat_width(ARRAY_DIM, DATA_WIDTH)-1:0] in_data,
    output logic                                         in_ready,
    output logic                                         arr_valid,
    input  logic                                         arr_ready,
    output logic                                         arr_first,
    output logic                                         arr_last,
    output logic [beat_width(ARRAY_DIM, DATA_WIDTH)-1:0] arr_data,
    input  logic                                         res_valid,
    input  logic [row_width(ARRAY_DIM, DATA_WIDTH)-1:0]  res_data,
    input  logic                                         res_error,
    output logic                                         res_ready,
    output logic                                         out_valid,
    output logic [DATA_WIDTH-1:0]                        out_data,
    output logic                                         out_last,
    input  logic                                         out_ready,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         error
);

    localparam int BEAT_W = beat_width(ARRAY_DIM, DATA_WIDTH);
    localparam int ROW_W  = row_width(ARRAY_DIM, DATA_WIDTH);
    localparam logic [DIM_WIDTH-1:0] TILE = DIM_WIDTH'(ARRAY_DIM);
    localparam logic [DIM_WIDTH-1:0] ONE  = DIM_WIDTH'(1);

    tile_state_e          state_q;
    logic [DIM_WIDTH-1:0] m_q, n_q, k_q;
    logic [DIM_WIDTH-1:0] k_cnt_q;
    logic [DIM_WIDTH-1:0] tm_base_q, tn_base_q;
    logic [DIM_WIDTH-1:0] row_cnt_q, row_idx_q, col_cnt_q;
    logic                 row_full_q;
    logic                 done_q;
    logic [ROW_W-1:0]     row_q;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [BEAT_W-1:0]    fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_level_unused;

    logic [DIM_WIDTH-1:0] m_rem, n_rem, rows_v, cols_v;
    logic                 tm_last, tn_last, row_emit, col_last, tile_done, word_hs;
    logic [DATA_WIDTH-1:0] word;

    tpu_beat_fifo #(
        .DATA_WIDTH (BEAT_W),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (abort),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (in_data),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_level_unused)
    );

    // Edge tiles: only the first rows_v rows and cols_v columns hold real results.
    assign m_rem    = m_q - tm_base_q;
    assign n_rem    = n_q - tn_base_q;
    assign rows_v   = (m_rem > TILE) ? TILE : m_rem;
    assign cols_v   = (n_rem > TILE) ? TILE : n_rem;
    assign tm_last  = (m_rem <= TILE);
    assign tn_last  = (n_rem <= TILE);
    assign row_emit = (row_idx_q < rows_v);
    assign col_last = (col_cnt_q == cols_v - ONE);

    assign in_ready  = !fifo_full && (state_q != ST_ERROR);
    assign fifo_push = in_valid && in_ready;
    assign arr_valid = (state_q == ST_FEED) && !fifo_empty;
    assign fifo_pop  = arr_valid && arr_ready;
    assign arr_first = arr_valid && (k_cnt_q == '0) && !accumulate_mode;
    assign arr_last  = arr_valid && (k_cnt_q == k_q - ONE);
    assign arr_data  = arr_valid ? fifo_head : '0;

    assign res_ready = (state_q == ST_COLLECT) && !row_full_q && (row_cnt_q < TILE);
    assign out_valid = (state_q == ST_COLLECT) && row_full_q && row_emit;
    assign out_last  = out_valid && tm_last && tn_last && col_last && (row_idx_q == rows_v - ONE);
    assign word_hs   = out_valid && out_ready;
    assign tile_done = (row_cnt_q == TILE) && !row_full_q;

    always_comb begin
        word = '0;
        for (int c = 0; c < ARRAY_DIM; c++) begin
            if (col_cnt_q == DIM_WIDTH'(c)) word = row_q[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign out_data = out_valid ? word : '0;
    assign busy     = (state_q != ST_IDLE);
    assign error    = (state_q == ST_ERROR);
    assign done     = done_q;

    always_ff @(posedge clk) begin
        if (res_valid && res_ready) row_q <= res_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            state_q    <= ST_IDLE;
            m_q        <= '0;
            n_q        <= '0;
            k_q        <= '0;
            k_cnt_q    <= '0;
            tm_base_q  <= '0;
            tn_base_q  <= '0;
            row_cnt_q  <= '0;
            row_idx_q  <= '0;
            col_cnt_q  <= '0;
            row_full_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        m_q       <= cfg_dims[3*DIM_WIDTH-1:2*DIM_WIDTH];
                        n_q       <= cfg_dims[2*DIM_WIDTH-1:DIM_WIDTH];
                        k_q       <= cfg_dims[DIM_WIDTH-1:0];
                        k_cnt_q   <= '0;
                        tm_base_q <= '0;
                        tn_base_q <= '0;
                        row_cnt_q <= '0;
                        if (cfg_dims[3*DIM_WIDTH-1:2*DIM_WIDTH] == '0 ||
                            cfg_dims[2*DIM_WIDTH-1:DIM_WIDTH] == '0 ||
                            cfg_dims[DIM_WIDTH-1:0] == '0) begin
                            state_q <= ST_ERROR;
                        end else begin
                            state_q <= ST_FEED;
                        end
                    end
                end
                ST_FEED: begin
                    if (fifo_pop) begin
                        if (arr_last) begin
                            k_cnt_q   <= '0;
                            row_cnt_q <= '0;
                            state_q   <= ST_COLLECT;
                        end else begin
                            k_cnt_q <= k_cnt_q + ONE;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (res_valid && res_error) begin
                        state_q <= ST_ERROR;
                    end else if (res_valid && res_ready) begin
                        row_full_q <= 1'b1;
                        row_idx_q  <= row_cnt_q;
                        row_cnt_q  <= row_cnt_q + ONE;
                        col_cnt_q  <= '0;
                    end else if (row_full_q && !row_emit) begin
                        row_full_q <= 1'b0;
                    end else if (word_hs) begin
                        if (col_last) begin
                            row_full_q <= 1'b0;
                            col_cnt_q  <= '0;
                        end else begin
                            col_cnt_q <= col_cnt_q + ONE;
                        end
                        // Masked rows may still be pending in the array; the job ends on its last real word.
                        if (out_last) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end else if (tile_done) begin
                        state_q <= ST_FEED;
                        if (tn_last) begin
                            tn_base_q <= '0;
                            tm_base_q <= tm_base_q + TILE;
                        end else begin
                            tn_base_q <= tn_base_q + TILE;
                        end
                    end
                end
                default: state_q <= ST_ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_tile_ctrl.sv
// Directed bench for tpu_tile_ctrl with ARRAY_DIM=4, FIFO_DEPTH=4 and a small array stub.
module tb_tpu_tile_ctrl;

    localparam int AD  = 4;
    localparam int DW  = 8;
    localparam int FD  = 4;
    localparam int DMW = 8;

    logic              clk = 1'b0;
    logic              rst_n, start, abort, accumulate_mode;
    logic [3*DMW-1:0]  cfg_dims;
    logic              in_valid, in_ready;
    logic [2*AD*DW-1:0] in_data, arr_data;
    logic              arr_valid, arr_ready, arr_first, arr_last;
    logic              res_valid, res_error, res_ready;
    logic [AD*DW-1:0]  res_data;
    logic              out_valid, out_last, out_ready;
    logic [DW-1:0]     out_data;
    logic              busy, done, error;

    always #5 clk = ~clk;

    tpu_tile_ctrl #(
        .ARRAY_DIM (AD), .DATA_WIDTH (DW), .FIFO_DEPTH (FD), .DIM_WIDTH (DMW)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
        .accumulate_mode (accumulate_mode), .cfg_dims (cfg_dims),
        .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready),
        .arr_valid (arr_valid), .arr_ready (arr_ready), .arr_first (arr_first),
        .arr_last (arr_last), .arr_data (arr_data),
        .res_valid (res_valid), .res_data (res_data), .res_error (res_error),
        .res_ready (res_ready), .out_valid (out_valid), .out_data (out_data),
        .out_last (out_last), .out_ready (out_ready),
        .busy (busy), .done (done), .error (error)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int beats_left = 0, beat_push_idx = 0, beat_pop_idx = 0;
    int pops, firsts, lasts, first_beat, last_beat, rows_acc;
    int rows_pend = 0, row_ptr = 0, tile_cur = 0, tiles_started = 0;
    int n_out_last, last_word_idx, last_cyc, done_cnt, done_cyc;
    int data_err, overlaps, stall_after = -1, stall_left = 0, stall_rr_bad, ov_in_err;
    bit err_en = 0, arr_bp = 0;
    logic [DW-1:0] got[$];
    int exp2[30] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,
                     32,33,36,37,40,41,44,45, 64,65,66,67, 96,97};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2*AD*DW-1:0] beat_val(input int j);
        return {32'hA5A5_0000 | 32'(j), 32'h5A5A_0000 | 32'(j)};
    endfunction

    task automatic step();
        bit lhs = 0;
        in_valid  = (beats_left > 0);
        in_data   = beat_val(beat_push_idx);
        res_valid = (rows_pend > 0);
        for (int c = 0; c < AD; c++) res_data[c*DW +: DW] = 8'(tile_cur*32 + row_ptr*4 + c);
        res_error = err_en && res_valid && (row_ptr == 2);
        arr_ready = arr_bp ? (cyc % 2 == 0) : 1'b1;
        out_ready = !(stall_left > 0 && got.size() == stall_after);
        #2;
        if (in_valid && in_ready && arr_valid && arr_ready) overlaps++;
        if (in_valid && in_ready) begin beats_left--; beat_push_idx++; end
        if (arr_valid && arr_ready) begin
            if (arr_data !== beat_val(beat_pop_idx)) data_err++;
            beat_pop_idx++;
            pops++;
            if (arr_first) begin firsts++; first_beat = pops; end
            if (arr_last)  begin lasts++; last_beat = pops; lhs = 1; end
        end
        if (res_valid && res_ready) begin row_ptr++; rows_pend--; rows_acc++; end
        if (!out_ready) begin stall_left--; if (res_ready) stall_rr_bad++; end
        if (out_valid && error) ov_in_err++;
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            if (out_last) begin n_out_last++; last_word_idx = got.size() - 1; last_cyc = cyc; end
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        abort = 1'b0;
        if (lhs) begin tile_cur = tiles_started; tiles_started++; rows_pend = AD; row_ptr = 0; end
    endtask

    task automatic run_job(input int m, input int n, input int k, input int nb, input bit acc,
                           input bit err, input int st_after, input bit bp, input bit stop_on_err);
        bit fin;
        pops = 0; firsts = 0; lasts = 0; first_beat = 0; last_beat = 0; rows_acc = 0;
        got.delete(); n_out_last = 0; last_word_idx = -1; last_cyc = -10; done_cnt = 0; done_cyc = -20;
        data_err = 0; overlaps = 0; stall_rr_bad = 0; ov_in_err = 0;
        tiles_started = 0; tile_cur = 0; rows_pend = 0; row_ptr = 0;
        beats_left += nb; accumulate_mode = acc; err_en = err; arr_bp = bp;
        stall_after = st_after; stall_left = (st_after >= 0) ? 10 : 0;
        cfg_dims = {8'(m), 8'(n), 8'(k)};
        start = 1'b1;
        step();
        for (int i = 0; i < 400; i++) begin
            if (done_cnt > 0 || (stop_on_err && error === 1'b1)) break;
            step();
        end
        fin = (done_cnt > 0) || (stop_on_err && error === 1'b1);
        check_eq("job_end_within_budget", fin, 1);
    endtask

    task automatic do_abort();
        beats_left = 0;
        abort = 1'b1;
        step();
        beat_pop_idx = beat_push_idx;
        rows_pend = 0;
    endtask

    function automatic int seq_word_errs();
        int e = 0;
        foreach (got[i]) if (got[i] !== 8'(i)) e++;
        return e;
    endfunction

    initial begin
        int e, base;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; accumulate_mode = 1'b0; cfg_dims = '0;
        in_valid = 1'b0; in_data = '0; arr_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        res_error = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_arr_valid", arr_valid, 0);
        check_eq("rst_arr_first", arr_first, 0);
        check_eq("rst_res_ready", res_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_last", out_last, 0);

        // Single full tile, k=2
        run_job(4, 4, 2, 2, 0, 0, -1, 0, 0);
        check_eq("t1_beats", pops, 2);
        check_eq("t1_first_cnt", firsts, 1);
        check_eq("t1_first_beat", first_beat, 1);
        check_eq("t1_last_beat", last_beat, 2);
        check_eq("t1_rows", rows_acc, 4);
        check_eq("t1_words", got.size(), 16);
        check_eq("t1_word_vals", seq_word_errs(), 0);
        check_eq("t1_out_last_cnt", n_out_last, 1);
        check_eq("t1_out_last_idx", last_word_idx, 15);
        check_eq("t1_done_cnt", done_cnt, 1);
        check_eq("t1_done_latency", done_cyc - last_cyc, 1);
        check_eq("t1_beat_data", data_err, 0);
        check_eq("t1_busy_after", busy, 0);

        // Edge tiles m=5, n=6, k=1 with array backpressure
        run_job(5, 6, 1, 4, 0, 0, -1, 1, 0);
        check_eq("t2_beats", pops, 4);
        check_eq("t2_firsts", firsts, 4);
        check_eq("t2_lasts", lasts, 4);
        check_eq("t2_words", got.size(), 30);
        e = 0;
        foreach (got[i]) if (i < 30 && got[i] !== 8'(exp2[i])) e++;
        check_eq("t2_word_vals", e, 0);
        check_eq("t2_out_last_idx", last_word_idx, 29);
        check_eq("t2_done_latency", done_cyc - last_cyc, 1);
        check_eq("t2_beat_data", data_err, 0);

        // Preload in IDLE, then drain with push/pop overlap
        base = beat_push_idx;
        beats_left = 5;
        repeat (6) step();
        check_eq("t3_preload_accepts", beat_push_idx - base, 4);
        check_eq("t3_in_ready_full", in_ready, 0);
        check_eq("t3_busy_idle", busy, 0);
        run_job(4, 4, 5, 0, 0, 0, -1, 0, 0);
        check_eq("t3_beats", pops, 5);
        check_eq("t3_beat_data", data_err, 0);
        check_eq("t3_overlap_seen", overlaps > 0, 1);
        check_eq("t3_words", got.size(), 16);
        check_eq("t3_in_ready_after", in_ready, 1);

        // Result error on row 2, then abort
        run_job(4, 4, 1, 3, 0, 1, -1, 0, 1);
        check_eq("t4_error", error, 1);
        check_eq("t4_in_ready", in_ready, 0);
        check_eq("t4_rows_before_err", rows_acc, 2);
        base = beat_push_idx;
        beats_left = 1;
        ov_in_err = 0;
        repeat (4) step();
        check_eq("t4_no_push_in_error", beat_push_idx - base, 0);
        check_eq("t4_no_out_valid", ov_in_err, 0);
        do_abort();
        check_eq("t4_abort_busy", busy, 0);
        check_eq("t4_abort_error", error, 0);
        check_eq("t4_abort_in_ready", in_ready, 1);
        base = beat_push_idx;
        beats_left = 5;
        repeat (6) step();
        check_eq("t4_fifo_flushed", beat_push_idx - base, 4);
        do_abort();

        // Zero dimension, then accumulate mode
        run_job(4, 4, 0, 0, 0, 0, -1, 0, 1);
        check_eq("t5_k0_error", error, 1);
        check_eq("t5_k0_busy", busy, 1);
        do_abort();
        run_job(4, 4, 2, 2, 1, 0, -1, 0, 0);
        check_eq("t5_acc_firsts", firsts, 0);
        check_eq("t5_acc_beats", pops, 2);
        check_eq("t5_acc_words", got.size(), 16);
        accumulate_mode = 1'b0;

        // Output stall of 10 cycles mid-row
        run_job(4, 4, 1, 1, 0, 0, 5, 0, 0);
        check_eq("t6_stall_done", stall_left, 0);
        check_eq("t6_res_ready_stall", stall_rr_bad, 0);
        check_eq("t6_words", got.size(), 16);
        check_eq("t6_word_vals", seq_word_errs(), 0);
        stall_after = -1;

        // Reset in the middle of a job
        cfg_dims = {8'd4, 8'd4, 8'd2};
        beats_left = 2;
        start = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("t7_rst_busy", busy, 0);
        check_eq("t7_rst_in_ready", in_ready, 1);
        check_eq("t7_rst_arr_valid", arr_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tpu_tile_ctrl.md
TPU_TILE_CTRL -- requirements
Module: tpu_tile_ctrl

Interface
REQ-001 SHALL have parameter ARRAY_DIM, default 8: systolic tile edge (rows = cols = ARRAY_DIM).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: element width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: input beat FIFO depth, a power of 2 and at least 2.
REQ-004 SHALL have parameter DIM_WIDTH, default 16: width of each matrix dimension.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port start  in  1  job start pulse; sampled only in IDLE.
REQ-008 SHALL have port abort  in  1  flush to IDLE; highest priority.
REQ-009 SHALL have port accumulate_mode  in  1  1 = never assert arr_first (accumulate across tiles/jobs).
REQ-010 SHALL have port cfg_dims  in  3*DIM_WIDTH  {m,n,k}, captured at start.
REQ-011 SHALL have port in_valid  in  1  input beat valid.
REQ-012 SHALL have port in_data  in  2*ARRAY_DIM*DATA_WIDTH  {B vector, A vector}, one k-slice of a tile.
REQ-013 SHALL have port in_ready  out  1  = !fifo_full && state != ERROR.
REQ-014 SHALL have port arr_valid  out  1  beat to array valid.
REQ-015 SHALL have port arr_ready  in  1  array accepts beat.
REQ-016 SHALL have port arr_first  out  1  first k beat of tile (clear accumulators).
REQ-017 SHALL have port arr_last  out  1  last k beat of tile.
REQ-018 SHALL have port arr_data  out  2*ARRAY_DIM*DATA_WIDTH  FIFO head, passed through unmodified.
REQ-019 SHALL have port res_valid  in  1  result row vector valid.
REQ-020 SHALL have port res_data  in  ARRAY_DIM*DATA_WIDTH  result row, element 0 in LSBs.
REQ-021 SHALL have port res_error  in  1  array overflow/underflow, qualified by res_valid.
REQ-022 SHALL have port res_ready  out  1  row register free.
REQ-023 SHALL have port out_valid  out  1  output word valid.
REQ-024 SHALL have port out_data  out  DATA_WIDTH  output element.
REQ-025 SHALL have port out_last  out  1  final word of job.
REQ-026 SHALL have port out_ready  in  1  consumer accepts word.
REQ-027 SHALL have ports busy/done/error  out  1 each: state != IDLE; one-cycle pulse on job completion; state == ERROR.

Function
REQ-028 SHALL implement states IDLE, FEED, COLLECT, ERROR: IDLE->ERROR on start if any of m,n,k is 0; IDLE->FEED on start otherwise; FEED->COLLECT after the arr_last handshake; COLLECT->FEED after ARRAY_DIM rows are accepted, if tiles remain; COLLECT->IDLE with done after the last word of the last tile; COLLECT->ERROR on res_valid && res_error; ERROR->IDLE only on abort.
REQ-029 SHALL tile m by n in ARRAY_DIM blocks, tiles_m = ceil(m/ARRAY_DIM) and tiles_n = ceil(n/ARRAY_DIM), tile_n innermost; each tile consumes exactly k FIFO beats.
REQ-030 SHALL drive arr_valid = (state == FEED) && !fifo_empty, combinationally from the FIFO head; a pop occurs on arr_valid && arr_ready; arr_first = (k_cnt == 0) && !accumulate_mode; arr_last = (k_cnt == k-1).
REQ-031 SHALL accept the input FIFO push on in_valid && in_ready in any state except ERROR, including IDLE preload; push and pop in the same cycle keep the count unchanged; a push while full is impossible because in_ready = 0.
REQ-032 SHALL accept exactly ARRAY_DIM rows per tile in COLLECT, one row register at a time, with res_ready = (state == COLLECT) && row register empty.
REQ-033 SHALL serialize each accepted row, one word per out_valid && out_ready, emitting only columns < min(ARRAY_DIM, n - tile_n*ARRAY_DIM); rows >= min(ARRAY_DIM, m - tile_m*ARRAY_DIM) are accepted but emit nothing; a row with zero emitted words frees the register next cycle.
REQ-034 SHALL emit m*n words per job in total; out_last coincides with the final word; done pulses the cycle after that handshake.
REQ-035 SHALL, on abort, within one cycle: go to IDLE, empty the FIFO, clear all counters and the row register, and deassert all valids; start is ignored while busy.
REQ-036 SHALL use counters sized DIM_WIDTH with no wrap within a legal job; the FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-037 SHALL, on rst_n == 0 at posedge: state IDLE, FIFO empty, in_ready 1 (after reset), all other outputs 0, counters 0; reset mid-job discards all data.

Structure
REQ-038 SHALL take the state enum and the beat/row width localparams from the shared package tpu_pkg.
REQ-039 SHALL implement the input FIFO as sub-module tpu_beat_fifo (DATA_WIDTH, DEPTH; push/pop/full/empty/count).

Verification (ARRAY_DIM=4, FIFO_DEPTH=4)
REQ-040 SHALL cover: m=n=4, k=2, 2 beats -> arr_first on beat 1, arr_last on beat 2, 4 rows -> 16 words, out_last on word 16, done 1 cycle later.
REQ-041 SHALL cover: m=5, n=6, k=1 -> 4 tiles, 4 beats consumed, exactly 30 words, edge columns/rows masked.
REQ-042 SHALL cover: 5 in_valid beats in IDLE -> 4 accepted, in_ready=0 from the 4th accept; start drains the FIFO with push/pop overlap.
REQ-043 SHALL cover: res_error on row 2 -> error=1, in_ready=0, no further out_valid; abort -> IDLE, FIFO empty next cycle.
REQ-044 SHALL cover: start with k=0 -> ERROR; accumulate_mode=1 -> arr_first never asserted.
REQ-045 SHALL cover: out_ready low 10 cycles mid-row -> res_ready=0, no word lost or duplicated.
